ibis_phase_accumulator_multi: RTL
=================================

# ibis_phase_accumulator_multi

Time-multiplexed bank of `CHANNELS` independent phase accumulators, each `PHASE_WIDTH` bits wide, sharing one adder. It services one channel per enabled cycle in round-robin order and streams each channel's updated phase, index and wrap flag downstream. Each channel can be reset to zero, can free-run, or can run one-shot (stop after its first wrap). It is the next generation of the Ibis quad phase accumulator, feeding the wavetable/oscillator stage.

## Interface
- `PHASE_WIDTH`, default 16: phase and increment width in bits, legal range 4..32.
- `CHANNELS`, default 4: channel count, legal range 2..16, need not be a power of two.
- `CH_BITS`, localparam `$clog2(CHANNELS)`: channel index width.
- `aclk`  in  1: single clock; all state changes on its rising edge.
- `areset`  in  1: asynchronous, active-high reset.
- `enable`  in  1: advance; when high, the current channel is serviced this cycle.
- `write_enable`  in  1: load `phase_in` into the increment register of `write_channel`.
- `write_channel`  in  CH_BITS: target channel for the increment write; values ≥ CHANNELS are ignored.
- `phase_in`  in  PHASE_WIDTH: new increment value.
- `oneshot_mask`  in  CHANNELS: bit c high puts channel c in one-shot mode; sampled at each service of c.
- `phase_reset`  in  CHANNELS: per-channel reset-request pulses.
- `out_valid`  out  1: registered; high for one cycle per serviced channel.
- `out_channel`  out  CH_BITS: index of the channel just serviced.
- `out_phase`  out  PHASE_WIDTH: new phase of that channel.
- `out_wrap`  out  1: high when that service overflowed past 2^PHASE_WIDTH.
- `phase_is_zero`  out  CHANNELS: bit c is combinational `phase[c] == 0`.

## Operation
- **State:**
  - per-channel `phase[c]` and `inc[c]`, each PHASE_WIDTH bits;
  - per-channel pending-reset bit `rst_pend[c]`;
  - per-channel done bit `done[c]`;
  - sequencer `cur_ch`, CH_BITS wide.
- **Sequencer:**
  - on each cycle with `enable=1`, `cur_ch` increments, wrapping from CHANNELS-1 to 0;
  - with `enable=0`, `cur_ch` holds.
- **Service of channel c = cur_ch, checked in priority order:**
  1. If `rst_pend[c]` is set or `phase_reset[c]` is high this cycle: `phase[c]` becomes 0, `done[c]` becomes 0, `rst_pend[c]` is cleared, `out_wrap` is 0.
  2. Else if `done[c]` is set: `phase[c]` holds, `out_wrap` is 0.
  3. Else compute a (PHASE_WIDTH+1)-bit sum = `phase[c] + inc[c]`:
     - `phase[c]` takes `sum[PHASE_WIDTH-1:0]`;
     - `out_wrap` takes `sum[PHASE_WIDTH]`;
     - if `out_wrap` is 1 and `oneshot_mask[c]` is 1, `phase[c]` is forced to 0 and `done[c]` is set.
- **Reset requests:**
  - `phase_reset[k]` high for a channel k ≠ cur_ch, or with `enable=0`, sets `rst_pend[k]`;
  - the pending request is applied at k's next service;
  - multiple pulses before that service collapse into one.
- **Increment writes:**
  - `inc[write_channel]` updates at the edge where `write_enable` is high, independent of `enable`;
  - if the written channel is serviced in the same cycle, the old increment is used and the new one applies from its next service.
- **Free-run mode** (`oneshot_mask[c]=0`): the phase wraps modulo 2^PHASE_WIDTH indefinitely.
- **Leaving one-shot:** clearing `oneshot_mask[c]` does not clear `done[c]`; only a phase reset or `areset` clears it.

## Timing
- **Reset values** (`areset` high, asynchronous):
  - all `phase`, `inc`, `rst_pend`, `done` = 0 and `cur_ch` = 0;
  - `out_valid` = 0, `out_channel` = 0, `out_phase` = 0, `out_wrap` = 0;
  - `phase_is_zero` = all ones.
- **Latency:** a service at edge t updates `phase[c]` at t, and `out_*` shows the result from t until the next edge. `out_valid` is high exactly in cycles following an enabled cycle.
- **`enable=0`:** `out_valid` goes to 0 on the next edge; `out_channel`, `out_phase` and `out_wrap` hold their last values.
- **Service rate:** each channel is serviced once every CHANNELS enabled cycles.
- **Reset mid-operation:** `areset` aborts any in-flight service; after release, the first enabled cycle services channel 0.

## Test plan
- **Basic wrap:** after reset, write `inc[0]=0x4000` and `inc[1..3]=0`, then hold `enable=1` for 16 cycles. Channel-0 outputs must be 0x4000, 0x8000, 0xC000, 0x0000 with `out_wrap=1` on the last, and `out_channel` must sequence 0,1,2,3,0…
- **Reset pulse:** with `inc[2]=0x1000` running, pulse `phase_reset[2]` while `cur_ch=0`. The next channel-2 output must be phase 0x0000 with wrap 0, followed by 0x1000.
- **One-shot:** set `oneshot_mask[1]=1` and `inc[1]=0x8000`. Channel-1 outputs must be 0x8000, then 0x0000 with wrap 1, then 0x0000 with wrap 0 repeatedly (`phase_is_zero[1]=1`). Pulsing `phase_reset[1]` must restart it at 0x8000 on the service after the reset service.
- **Write collision:** write `inc[3]=0x0100` in the same cycle channel 3 is serviced with old `inc[3]=0x0010` from phase 0. Output must be 0x0010; the next channel-3 service must output 0x0110.
- **Stall:** drop `enable` for 5 cycles mid-stream. `out_valid=0`, `cur_ch` holds and phases hold, and the stream resumes with the next channel with no skipped or duplicated service.
- **Async reset:** assert `areset` between clock edges while `inc[0]=0xFFFF`. All outputs must go to their reset values immediately, with no residual wrap.

Source files
------------

// File: rtl/ibis_phase_accumulator_multi_if.sv
// Bus bundle for ibis_phase_accumulator_multi.
// master: controller side, drives control/increment inputs and observes the output stream.
// slave : accumulator side.
//   enable        advance the round-robin sequencer and service the current channel
//   write_enable  load phase_in into inc[write_channel]
//   write_channel target channel of the increment write (out-of-range values ignored)
//   phase_in      increment value to load
//   oneshot_mask  per-channel one-shot mode select
//   phase_reset   per-channel phase reset request pulses
//   out_valid     one-cycle strobe per serviced channel
//   out_channel   channel index just serviced
//   out_phase     updated phase of that channel
//   out_wrap      that service overflowed past 2^PHASE_WIDTH
//   phase_is_zero per-channel combinational phase == 0 flags
interface ibis_phase_accumulator_multi_if #(
  parameter int PHASE_WIDTH = 16,
  parameter int CHANNELS    = 4
);
  localparam int CH_BITS = $clog2(CHANNELS);

  logic                   enable;
  logic                   write_enable;
  logic [CH_BITS-1:0]     write_channel;
  logic [PHASE_WIDTH-1:0] phase_in;
  logic [CHANNELS-1:0]    oneshot_mask;
  logic [CHANNELS-1:0]    phase_reset;
  logic                   out_valid;
  logic [CH_BITS-1:0]     out_channel;
  logic [PHASE_WIDTH-1:0] out_phase;
  logic                   out_wrap;
  logic [CHANNELS-1:0]    phase_is_zero;

  modport master (
    output enable, write_enable, write_channel, phase_in, oneshot_mask, phase_reset,
    input  out_valid, out_channel, out_phase, out_wrap, phase_is_zero
  );

  modport slave (
    input  enable, write_enable, write_channel, phase_in, oneshot_mask, phase_reset,
    output out_valid, out_channel, out_phase, out_wrap, phase_is_zero
  );
endinterface

// File: rtl/ibis_phase_accumulator_multi.sv
// Time-multiplexed bank of CHANNELS phase accumulators sharing one adder.
// One channel is serviced per enabled cycle in round-robin order; each service
// streams the channel index, its new phase and its wrap flag (registered).
// Channels may be free-running, one-shot (park at zero after the first wrap),
// or reset to zero by a request that is held pending until the channel's turn.
// Ports:
//   aclk   rising-edge clock
//   areset asynchronous active-high reset
//   bus    ibis_phase_accumulator_multi_if.slave (see interface file for signals)
module ibis_phase_accumulator_multi #(
  parameter int PHASE_WIDTH = 16,
  parameter int CHANNELS    = 4
) (
  input  logic                          aclk,
  input  logic                          areset,
  ibis_phase_accumulator_multi_if.slave bus
);
  localparam int CH_BITS = $clog2(CHANNELS);
  localparam logic [CH_BITS-1:0] LAST_CH = CH_BITS'(CHANNELS - 1);

  logic [PHASE_WIDTH-1:0] phase_r [CHANNELS];
  logic [PHASE_WIDTH-1:0] inc_r   [CHANNELS];
  logic [CHANNELS-1:0]    rst_pend_r;
  logic [CHANNELS-1:0]    done_r;
  logic [CH_BITS-1:0]     cur_ch_r;

  logic                   out_valid_r;
  logic [CH_BITS-1:0]     out_channel_r;
  logic [PHASE_WIDTH-1:0] out_phase_r;
  logic                   out_wrap_r;

  logic [PHASE_WIDTH:0]   sum_s;
  logic [PHASE_WIDTH-1:0] phase_nxt_s;
  logic                   done_nxt_s;
  logic                   wrap_s;
  logic                   rst_req_s;
  logic [CHANNELS-1:0]    phase_is_zero_s;

  // Shared adder and next-state of the channel currently selected by the sequencer
  always_comb begin
    sum_s       = {1'b0, phase_r[cur_ch_r]} + {1'b0, inc_r[cur_ch_r]};
    rst_req_s   = rst_pend_r[cur_ch_r] | bus.phase_reset[cur_ch_r];
    phase_nxt_s = phase_r[cur_ch_r];
    done_nxt_s  = done_r[cur_ch_r];
    wrap_s      = 1'b0;
    if (rst_req_s) begin
      // A reset request (pending or arriving now) beats everything and re-arms one-shot
      phase_nxt_s = '0;
      done_nxt_s  = 1'b0;
    end else if (done_r[cur_ch_r]) begin
      // Finished one-shot channel parks at its current (zero) phase
      phase_nxt_s = phase_r[cur_ch_r];
      done_nxt_s  = 1'b1;
    end else begin
      wrap_s = sum_s[PHASE_WIDTH];
      if (sum_s[PHASE_WIDTH] && bus.oneshot_mask[cur_ch_r]) begin
        phase_nxt_s = '0;
        done_nxt_s  = 1'b1;
      end else begin
        phase_nxt_s = sum_s[PHASE_WIDTH-1:0];
        done_nxt_s  = 1'b0;
      end
    end
  end

  // Round-robin sequencer, advances only on enabled cycles
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cur_ch_r <= '0;
    end else if (bus.enable) begin
      cur_ch_r <= (cur_ch_r == LAST_CH) ? '0 : cur_ch_r + CH_BITS'(1);
    end else begin
      cur_ch_r <= cur_ch_r;
    end
  end

  // Per-channel phase, done and pending-reset state
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        phase_r[k] <= '0;
      end
      done_r     <= '0;
      rst_pend_r <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (bus.enable && (cur_ch_r == CH_BITS'(k))) begin
          // Serviced channel consumes any pending request (several pulses collapse into one)
          phase_r[k]    <= phase_nxt_s;
          done_r[k]     <= done_nxt_s;
          rst_pend_r[k] <= 1'b0;
        end else if (bus.phase_reset[k]) begin
          rst_pend_r[k] <= 1'b1;
        end else begin
          rst_pend_r[k] <= rst_pend_r[k];
        end
      end
    end
  end

  // Increment registers; a same-cycle service still sees the old value
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        inc_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        // Only in-range channel indices can match, so out-of-range writes fall through
        if (bus.write_enable && (bus.write_channel == CH_BITS'(k))) begin
          inc_r[k] <= bus.phase_in;
        end else begin
          inc_r[k] <= inc_r[k];
        end
      end
    end
  end

  // Output stream register; payload holds while enable is low
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      out_valid_r   <= 1'b0;
      out_channel_r <= '0;
      out_phase_r   <= '0;
      out_wrap_r    <= 1'b0;
    end else if (bus.enable) begin
      out_valid_r   <= 1'b1;
      out_channel_r <= cur_ch_r;
      out_phase_r   <= phase_nxt_s;
      out_wrap_r    <= wrap_s;
    end else begin
      out_valid_r   <= 1'b0;
      out_channel_r <= out_channel_r;
      out_phase_r   <= out_phase_r;
      out_wrap_r    <= out_wrap_r;
    end
  end

  // Zero-phase flags straight from the phase registers
  always_comb begin
    phase_is_zero_s = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      phase_is_zero_s[k] = (phase_r[k] == '0);
    end
  end

  assign bus.out_valid     = out_valid_r;
  assign bus.out_channel   = out_channel_r;
  assign bus.out_phase     = out_phase_r;
  assign bus.out_wrap      = out_wrap_r;
  assign bus.phase_is_zero = phase_is_zero_s;
endmodule
